// File: rtl/nncu_pkg.sv
// Shared definitions for the NNCU memory-access responder.
//   state_e   : responder FSM states
//   req_id_t  : requester identifier (F = forward engine, B = back-prop engine, H = host)
//   NNCU_DATA_W : default data width of every port and of the RAM
package nncu_pkg;

    localparam int unsigned NNCU_DATA_W = 16;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRespond
    } state_e;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_F = 2'd0;
    localparam req_id_t REQ_B = 2'd1;
    localparam req_id_t REQ_H = 2'd2;

endpackage

// File: rtl/mmu_grant_arbiter.sv
// Three-way arbiter for the MMU responder.
// F and B share round-robin priority; the host H is granted only when neither engine requests,
// unless it has lost STARVE_LIMIT arbitrations in a row, in which case it wins outright.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   arb_i                : arbitration strobe; history updates only when high and a grant is made
//   f_req_i/b_req_i/h_req_i : request bits
//   grant_valid_o        : at least one request present
//   grant_o              : winning requester ID (combinational)
module mmu_grant_arbiter
    import nncu_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    arb_i,
    input  logic    f_req_i,
    input  logic    b_req_i,
    input  logic    h_req_i,
    output logic    grant_valid_o,
    output req_id_t grant_o
);

    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

    req_id_t         last_q, last_d;
    logic [CntW-1:0] starve_q, starve_d;

    always_comb begin
        grant_o       = REQ_F;
        grant_valid_o = f_req_i | b_req_i | h_req_i;
        if (h_req_i && (starve_q >= Limit)) begin
            grant_o = REQ_H;
        end else if (f_req_i && b_req_i) begin
            grant_o = (last_q == REQ_B) ? REQ_F : REQ_B;
        end else if (f_req_i) begin
            grant_o = REQ_F;
        end else if (b_req_i) begin
            grant_o = REQ_B;
        end else if (h_req_i) begin
            grant_o = REQ_H;
        end
    end

    always_comb begin
        last_d   = last_q;
        starve_d = starve_q;
        if (arb_i && grant_valid_o) begin
            if (grant_o == REQ_H) begin
                starve_d = '0;
            end else begin
                last_d = grant_o;
                // Host lost this round; count it, saturating at the limit.
                if (h_req_i && (starve_q < Limit)) begin
                    starve_d = starve_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q   <= REQ_B;
            starve_q <= '0;
        end else begin
            last_q   <= last_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mmu_responder.sv
// Responder side of the NNCU memory-access interface.
// Arbitrates between the forward engine (F), back-prop engine (B) and host (H), performs one
// access on a synchronous single-port RAM and returns a one-cycle ready/ack pulse two cycles
// after the request is sampled (IDLE -> ACCESS -> RESPOND).
// Ports:
//   clk_i, rst_ni                         : clock, asynchronous active-low reset
//   f_*/b_*                               : valid/ready request ports with read data
//   h_*                                   : host req/ack port with read data
//   err_o                                 : pulses with ready/ack on an out-of-range access
//   mem_en_o/mem_we_o/mem_adr_o/mem_wdata_o : RAM command
//   mem_rdata_i                           : RAM read data, valid the cycle after mem_en_o
module mmu_responder
    import nncu_pkg::*;
#(
    parameter int unsigned DATA_W       = NNCU_DATA_W,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              f_valid_i,
    input  logic              f_we_i,
    input  logic [ADDR_W-1:0] f_adr_i,
    input  logic [DATA_W-1:0] f_wdata_i,
    output logic              f_ready_o,
    output logic [DATA_W-1:0] f_rdata_o,
    input  logic              b_valid_i,
    input  logic              b_we_i,
    input  logic [ADDR_W-1:0] b_adr_i,
    input  logic [DATA_W-1:0] b_wdata_i,
    output logic              b_ready_o,
    output logic [DATA_W-1:0] b_rdata_o,
    input  logic              h_req_i,
    input  logic              h_we_i,
    input  logic [ADDR_W-1:0] h_adr_i,
    input  logic [DATA_W-1:0] h_wdata_i,
    output logic              h_ack_o,
    output logic [DATA_W-1:0] h_rdata_o,
    output logic              err_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_adr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    req_id_t           gnt_q;
    logic              we_q;
    logic              oor_q;
    logic [MEM_AW-1:0] adr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] f_rdata_q, b_rdata_q, h_rdata_q;

    logic              arb;
    logic              grant_valid;
    req_id_t           grant;
    logic              req_we;
    logic [ADDR_W-1:0] req_adr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_oor;
    logic              resp_rd;
    logic [DATA_W-1:0] rd_val;

    assign arb = (state_q == StIdle);

    mmu_grant_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .arb_i         (arb),
        .f_req_i       (f_valid_i),
        .b_req_i       (b_valid_i),
        .h_req_i       (h_req_i),
        .grant_valid_o (grant_valid),
        .grant_o       (grant)
    );

    // Select the winner's request fields.
    always_comb begin
        req_we    = f_we_i;
        req_adr   = f_adr_i;
        req_wdata = f_wdata_i;
        case (grant)
            REQ_B: begin
                req_we    = b_we_i;
                req_adr   = b_adr_i;
                req_wdata = b_wdata_i;
            end
            REQ_H: begin
                req_we    = h_we_i;
                req_adr   = h_adr_i;
                req_wdata = h_wdata_i;
            end
            default: ;
        endcase
        req_oor = ({1'b0, req_adr} >= DepthA);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant_valid) state_d = StAccess;
            StAccess:  state_d = StRespond;
            StRespond: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= REQ_F;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (arb && grant_valid) begin
                gnt_q   <= grant;
                we_q    <= req_we;
                oor_q   <= req_oor;
                adr_q   <= req_adr[MEM_AW-1:0];
                wdata_q <= req_wdata;
            end
        end
    end

    // RAM command only during an in-range ACCESS; otherwise all zero.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_adr_o   = '0;
        mem_wdata_o = '0;
        if ((state_q == StAccess) && !oor_q) begin
            mem_en_o    = 1'b1;
            mem_we_o    = we_q;
            mem_adr_o   = adr_q;
            mem_wdata_o = wdata_q;
        end
    end

    // Read data is forwarded combinationally during RESPOND so it lines up with the ready
    // pulse, and captured so it holds until that port's next completed read.
    assign resp_rd = (state_q == StRespond) && !we_q;
    assign rd_val  = oor_q ? '0 : mem_rdata_i;

    always_comb begin
        f_ready_o = (state_q == StRespond) && (gnt_q == REQ_F);
        b_ready_o = (state_q == StRespond) && (gnt_q == REQ_B);
        h_ack_o   = (state_q == StRespond) && (gnt_q == REQ_H);
        err_o     = (state_q == StRespond) && oor_q;
        f_rdata_o = (resp_rd && (gnt_q == REQ_F)) ? rd_val : f_rdata_q;
        b_rdata_o = (resp_rd && (gnt_q == REQ_B)) ? rd_val : b_rdata_q;
        h_rdata_o = (resp_rd && (gnt_q == REQ_H)) ? rd_val : h_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_rdata_q <= '0;
            b_rdata_q <= '0;
            h_rdata_q <= '0;
        end else begin
            f_rdata_q <= f_rdata_o;
            b_rdata_q <= b_rdata_o;
            h_rdata_q <= h_rdata_o;
        end
    end

endmodule

// File: tb/tb_mmu_responder.sv
// Directed bench for mmu_responder: a vector table of single transactions plus hand-written
// round-robin, starvation and reset-mid-access sequences. A behavioural RAM model sits on
// the mem_* port.
module tb_mmu_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_valid = 0, f_we = 0, b_valid = 0, b_we = 0, h_req = 0, h_we = 0;
    logic [15:0] f_adr = 0, f_wdata = 0, b_adr = 0, b_wdata = 0, h_adr = 0, h_wdata = 0;
    logic        f_ready, b_ready, h_ack, err, mem_en, mem_we;
    logic [15:0] f_rdata, b_rdata, h_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_adr;

    // RAM model with a preload port used while the DUT is held in reset.
    logic [15:0] ram [1024];
    logic [15:0] rd_q = '0;
    logic        pl_en = 1'b0;
    logic [9:0]  pl_adr = '0;
    logic [15:0] pl_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) ram[pl_adr] <= pl_data;
        else if (mem_en) begin
            if (mem_we) ram[mem_adr] <= mem_wdata;
            else rd_q <= ram[mem_adr];
        end
    end
    assign mem_rdata = rd_q;

    mmu_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .f_valid_i   (f_valid),
        .f_we_i      (f_we),
        .f_adr_i     (f_adr),
        .f_wdata_i   (f_wdata),
        .f_ready_o   (f_ready),
        .f_rdata_o   (f_rdata),
        .b_valid_i   (b_valid),
        .b_we_i      (b_we),
        .b_adr_i     (b_adr),
        .b_wdata_i   (b_wdata),
        .b_ready_o   (b_ready),
        .b_rdata_o   (b_rdata),
        .h_req_i     (h_req),
        .h_we_i      (h_we),
        .h_adr_i     (h_adr),
        .h_wdata_i   (h_wdata),
        .h_ack_o     (h_ack),
        .h_rdata_o   (h_rdata),
        .err_o       (err),
        .mem_en_o    (mem_en),
        .mem_we_o    (mem_we),
        .mem_adr_o   (mem_adr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] readies();
        return {h_ack, b_ready, f_ready};
    endfunction

    function automatic logic [15:0] port_rdata(input int p);
        case (p)
            0: return f_rdata;
            1: return b_rdata;
            default: return h_rdata;
        endcase
    endfunction

    function automatic logic [79:0] all_outs();
        return {f_ready, f_rdata, b_ready, b_rdata, h_ack, h_rdata, err, mem_en, mem_we,
                mem_adr, mem_wdata};
    endfunction

    task automatic drive(input int p, input logic v, input logic we, input logic [15:0] adr,
                         input logic [15:0] wd);
        case (p)
            0: begin f_valid = v; f_we = we; f_adr = adr; f_wdata = wd; end
            1: begin b_valid = v; b_we = we; b_adr = adr; b_wdata = wd; end
            default: begin h_req = v; h_we = we; h_adr = adr; h_wdata = wd; end
        endcase
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_adr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("reset_outputs", 128'(all_outs()), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] adr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    // Single transaction starting with the DUT in IDLE; checks ACCESS and RESPOND cycles.
    task automatic txn(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("v%0d", idx);
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.adr, v.wdata);
        @(negedge clk);
        chk({nm, ".mem_en"}, 128'(mem_en), 128'(!v.exp_err));
        if (!v.exp_err) chk({nm, ".mem_adr"}, 128'(mem_adr), 128'(v.adr[9:0]));
        chk({nm, ".early_ready"}, 128'(readies()), 128'h0);
        @(negedge clk);
        chk({nm, ".ready"}, 128'(readies()), 128'(3'b001 << v.port));
        chk({nm, ".err"}, 128'(err), 128'(v.exp_err));
        if (!v.we) chk({nm, ".rdata"}, 128'(port_rdata(v.port)), 128'(v.exp_rd));
        drive(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    // F/B/H all read address 5 continuously until their request counts are used up; the
    // observed completion order is compared with exp_order.
    task automatic stream(input int nf, input int nb, input int nh, input int exp_order [10],
                          input int n, input bit chk_gap, input string nm);
        int k = 0;
        int last_cyc = 0;
        int cyc = 0;
        int g;
        @(negedge clk);
        if (nf > 0) drive(0, 1'b1, 1'b0, 16'd5, 16'h0);
        if (nb > 0) drive(1, 1'b1, 1'b0, 16'd5, 16'h0);
        if (nh > 0) drive(2, 1'b1, 1'b0, 16'd5, 16'h0);
        while (k < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (readies() != 3'b000) begin
                chk($sformatf("%s.grant%0d", nm, k), 128'(readies()),
                    128'(3'b001 << exp_order[k]));
                if (chk_gap && k > 0) chk($sformatf("%s.gap%0d", nm, k), 128'(cyc - last_cyc), 128'd3);
                last_cyc = cyc;
                g = f_ready ? 0 : (b_ready ? 1 : 2);
                case (g)
                    0: begin nf--; if (nf == 0) f_valid = 1'b0; end
                    1: begin nb--; if (nb == 0) b_valid = 1'b0; end
                    default: begin nh--; if (nh == 0) h_req = 1'b0; end
                endcase
                k++;
            end
        end
        if (k < n) begin
            errors++;
            checks++;
            $display("FAIL %s.timeout: got %0d grants expected %0d", nm, k, n);
        end
        f_valid = 1'b0; b_valid = 1'b0; h_req = 1'b0;
    endtask

    initial begin
        vec_t vecs [11];
        int rr_order [10];
        int st_order [10];

        vecs[0]  = '{0, 1'b0, 16'd5,    16'h0,    16'hBEEF, 1'b0};
        vecs[1]  = '{1, 1'b1, 16'd12,   16'h1234, 16'h0,    1'b0};
        vecs[2]  = '{2, 1'b0, 16'd12,   16'h0,    16'h1234, 1'b0};
        vecs[3]  = '{0, 1'b1, 16'h0400, 16'hDEAD, 16'h0,    1'b1};
        vecs[4]  = '{0, 1'b0, 16'h0400, 16'h0,    16'h0,    1'b1};
        vecs[5]  = '{1, 1'b0, 16'h0000, 16'h0,    16'hA5A5, 1'b0};
        vecs[6]  = '{2, 1'b0, 16'h03FF, 16'h0,    16'h55AA, 1'b0};
        vecs[7]  = '{0, 1'b1, 16'h03FF, 16'h0F0F, 16'h0,    1'b0};
        vecs[8]  = '{1, 1'b0, 16'h03FF, 16'h0,    16'h0F0F, 1'b0};
        vecs[9]  = '{2, 1'b0, 16'hFFFF, 16'h0,    16'h0,    1'b1};
        vecs[10] = '{0, 1'b0, 16'd5,    16'h0,    16'hBEEF, 1'b0};
        rr_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
        st_order = '{0, 1, 0, 1, 2, 0, 1, 0, 1, 2};

        // Preload while held in reset.
        preload(10'd5, 16'hBEEF);
        preload(10'd0, 16'hA5A5);
        preload(10'd1023, 16'h55AA);
        chk("reset_outputs", 128'(all_outs()), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) txn(vecs[i], i);
        @(negedge clk);
        chk("f_rdata_hold", 128'(f_rdata), 128'hBEEF);
        chk("b_rdata_hold", 128'(b_rdata), 128'h0F0F);
        chk("h_rdata_hold", 128'(h_rdata), 128'h0);
        chk("ram0_untouched", 128'(ram[0]), 128'hA5A5);

        // Reset during ACCESS: outputs clear at once, no ready, reissue completes.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'd5, 16'h0);
        @(negedge clk);
        chk("rst_mid.mem_en", 128'(mem_en), 128'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_mid.outs", 128'(all_outs()), 128'h0);
        @(negedge clk);
        chk("rst_mid.no_ready", 128'(readies()), 128'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.access", 128'({readies(), mem_en}), 128'h1);
        @(negedge clk);
        chk("rst_mid.ready", 128'(readies()), 128'h1);
        chk("rst_mid.rdata", 128'(f_rdata), 128'hBEEF);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);

        do_reset();
        stream(4, 4, 0, rr_order, 8, 1'b1, "rr");

        do_reset();
        stream(4, 4, 2, st_order, 10, 1'b0, "starve");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmu_responder.md
Name: mmu_responder

Overview:
- Responder/target side of the NNCU memory-access interface.
- Accepts valid/ready requests from the forward-propagation engine (port F) and the back-propagation engine (port B), plus a host req/ack port (port H).
- Arbitrates among the three, drives one synchronous single-port weight/activation RAM, and returns read data with a one-cycle ready/ack pulse.
- Replaces the static priority mux in front of the MMU; it has real handshakes and starvation-free arbitration.

Parameters:
- DATA_W, 16, data width of all ports and the RAM
- ADDR_W, 16, request address width on all ports
- DEPTH, 1024, RAM word count; addresses >= DEPTH are out of range
- MEM_AW, 10, RAM address width, clog2(DEPTH)
- STARVE_LIMIT, 4, lost arbitrations after which the host gets top priority

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- f_valid  input  1  port F request
- f_we  input  1  port F write enable
- f_adr  input  ADDR_W  port F address
- f_wdata  input  DATA_W  port F write data
- f_ready  output  1  port F completion pulse
- f_rdata  output  DATA_W  port F read data
- b_valid / b_we / b_adr / b_wdata / b_ready / b_rdata  same set as port F, for port B
- h_req / h_we / h_adr / h_wdata / h_ack / h_rdata  same set as port F, for port H
- err  output  1  one-cycle pulse on an out-of-range access
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write
- mem_adr  output  MEM_AW  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid the cycle after mem_en

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - All ready/ack, err and mem_* outputs are 0; all rdata outputs are 0.
  - last_grant=B, so F wins the first tie; starve_cnt=0.
  - Reset mid-transaction abandons the access and produces no ready/ack; the requester must reissue.
- FSM states are IDLE, ACCESS and RESPOND.
- IDLE:
  - Sample requests; if any is present, latch the winner ID, we, address and wdata, then go to ACCESS.
  - Stay in IDLE otherwise.
- Arbitration (evaluated only in IDLE):
  - If h_req=1 and starve_cnt >= STARVE_LIMIT, grant H.
  - Otherwise F and B round-robin: when both are valid, grant the one opposite last_grant.
  - If only one of F/B is valid, grant it.
  - Grant H only when neither F nor B is valid.
  - starve_cnt increments on each grant to F/B while h_req=1, clears on any grant to H, and saturates at STARVE_LIMIT.
- ACCESS (1 cycle):
  - In range: mem_en=1, mem_we=latched we, mem_adr=latched address[MEM_AW-1:0], mem_wdata=latched wdata.
  - Out of range: mem_en=0; no write occurs.
  - Next state is RESPOND.
- RESPOND (1 cycle):
  - Pulse ready/ack of the granted port only.
  - On a read, that port's rdata takes mem_rdata, or 0 if out of range.
  - On a write, rdata is unchanged.
  - err pulses in this cycle if the access was out of range.
  - Next state is IDLE.
- Latency: a request sampled in IDLE at cycle N gets ready at N+2. Peak throughput is one access per 3 cycles.
- Handshake rules:
  - The requester holds valid/req, we, address and wdata stable until it sees ready/ack.
  - Request inputs are ignored outside IDLE.
  - The requester may present a new request the cycle after ready; the responder samples it in the following IDLE.
  - rdata is held until that port's next completed read.
- Simultaneous events: all three requests present at once resolve by the arbitration rules above; losing requests wait with no loss.
- Width rules: all fields pass through unmodified; there is no sign extension or arithmetic on data.

Decomposition:
- Shared package nncu_pkg holds:
  - the state enum (IDLE, ACCESS, RESPOND)
  - requester ID encoding (REQ_F=0, REQ_B=1, REQ_H=2)
  - the DATA_W constant
- One sub-module, mmu_grant_arbiter: holds last_grant and starve_cnt, takes the three request bits plus an arbitrate strobe, and outputs the grant ID.

Test Plan:
- Single read: preload RAM[5]=16'hBEEF; f_valid=1, f_adr=5 at cycle 0 -> mem_en at cycle 1, f_ready pulse with f_rdata=16'hBEEF at cycle 2, b_ready/h_ack stay 0.
- Write then read: b_we=1, b_adr=12, b_wdata=16'h1234, completes with b_ready -> then h_req read of address 12 returns h_rdata=16'h1234.
- Round-robin: f_valid and b_valid held continuously with 4 requests each -> grant order F,B,F,B,...; each ready arrives 3 cycles after the previous one.
- Starvation: f_valid and b_valid held continuously with h_req=1 -> H is granted after exactly 4 F/B grants, and starve_cnt then clears.
- Out of range: f_adr=16'h0400 with write, then read -> mem_en never asserted, err pulses with f_ready, read gives f_rdata=0, RAM is unchanged.
- Reset mid-access: assert rst=0 during ACCESS -> all outputs are 0 immediately, no f_ready pulse; after release, the reissued request completes normally.
